poly_loader: RTL

POLY_LOADER -- requirements
Module: poly_loader

---
 rtl/poly_loader_if.sv | 55 +++++
 rtl/poly_loader.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/poly_loader_if.sv
// Shared polygon-loader constants plus the command handshake interface between requester and loader.
package poly_loader_pkg;
  localparam int unsigned WPX     = 10;
  localparam int unsigned WPY     = 9;
  localparam int unsigned WCOLOR  = 8;
  localparam int unsigned N_POLY  = 3;
  localparam int unsigned PIDX_W  = 2;
  localparam int unsigned FIELD_W = 3;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [FIELD_W-1:0] {
    FLD_V0_X  = 3'd0,
    FLD_V0_Y  = 3'd1,
    FLD_V1_X  = 3'd2,
    FLD_V1_Y  = 3'd3,
    FLD_V2_X  = 3'd4,
    FLD_V2_Y  = 3'd5,
    FLD_COLOR = 3'd6,
    FLD_EN    = 3'd7
  } field_e;

  // One polygon's worth of rasterizer parameters.
  typedef struct packed {
    logic              en;
    logic [WCOLOR-1:0] color;
    logic [WPY-1:0]    v2_y;
    logic [WPX-1:0]    v2_x;
    logic [WPY-1:0]    v1_y;
    logic [WPX-1:0]    v1_x;
    logic [WPY-1:0]    v0_y;
    logic [WPX-1:0]    v0_x;
  } poly_t;
endpackage

interface poly_loader_if;
  import poly_loader_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_commit;
  logic [PIDX_W-1:0]   cmd_poly;
  logic [FIELD_W-1:0]  cmd_field;
  logic [DATA_W-1:0]   cmd_data;

  modport master (
    output cmd_valid, cmd_commit, cmd_poly, cmd_field, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_commit, cmd_poly, cmd_field, cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/poly_loader.sv
// Double-buffered polygon parameter loader: commands fill a shadow set, a commit copies it to the
// active set at the next frame_start. Optional shadow readback port under POLY_LOADER_READBACK_EN.
module poly_loader
  import poly_loader_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  poly_loader_if.slave               cmd,
  input  logic                       frame_start,
  output logic                       commit_done,
  output logic [CNT_W-1:0]           frame_count,
  output logic [N_POLY-1:0]          cmp_en,
  output logic [N_POLY*WPX-1:0]      v0_x,
  output logic [N_POLY*WPY-1:0]      v0_y,
  output logic [N_POLY*WPX-1:0]      v1_x,
  output logic [N_POLY*WPY-1:0]      v1_y,
  output logic [N_POLY*WPX-1:0]      v2_x,
  output logic [N_POLY*WPY-1:0]      v2_y,
  output logic [N_POLY*WCOLOR-1:0]   poly_color
`ifdef POLY_LOADER_READBACK_EN
  ,
  input  logic [PIDX_W-1:0]          rd_poly,
  input  logic [FIELD_W-1:0]         rd_field,
  output logic [DATA_W-1:0]          rd_data
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  state_e state;
  state_e state_next;
  logic   accept_c;
  logic   wr_c;
  logic   copy_c;

  poly_t  shadow [N_POLY];
  poly_t  active [N_POLY];

  // State register; ready is a flop that mirrors the upcoming state so it never sees cmd_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cmd.cmd_ready <= 1'b1;
    end else begin
      state         <= state_next;
      cmd.cmd_ready <= (state_next == ST_IDLE);
    end
  end

  always_comb begin
    state_next = state;
    wr_c       = 1'b0;
    copy_c     = 1'b0;
    accept_c   = cmd.cmd_valid & cmd.cmd_ready;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          if (cmd.cmd_commit) begin
            state_next = ST_PENDING;
          end else begin
            wr_c = (32'(cmd.cmd_poly) < N_POLY);
          end
        end
      end
      ST_PENDING: begin
        if (frame_start) begin
          copy_c     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Shadow set: field writes truncate the LSB-aligned data to the field width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_POLY; i++) begin
        shadow[i] <= '0;
      end
    end else if (wr_c) begin
      for (int i = 0; i < N_POLY; i++) begin
        if (cmd.cmd_poly == PIDX_W'(i)) begin
          case (field_e'(cmd.cmd_field))
            FLD_V0_X:  shadow[i].v0_x  <= WPX'(cmd.cmd_data);
            FLD_V0_Y:  shadow[i].v0_y  <= WPY'(cmd.cmd_data);
            FLD_V1_X:  shadow[i].v1_x  <= WPX'(cmd.cmd_data);
            FLD_V1_Y:  shadow[i].v1_y  <= WPY'(cmd.cmd_data);
            FLD_V2_X:  shadow[i].v2_x  <= WPX'(cmd.cmd_data);
            FLD_V2_Y:  shadow[i].v2_y  <= WPY'(cmd.cmd_data);
            FLD_COLOR: shadow[i].color <= WCOLOR'(cmd.cmd_data);
            FLD_EN:    shadow[i].en    <= cmd.cmd_data[0];
            default:   ;
          endcase
        end
      end
    end
  end

  // Active set, commit pulse and commit counter all update on the completing frame_start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_POLY; i++) begin
        active[i] <= '0;
      end
      commit_done <= 1'b0;
      frame_count <= '0;
    end else begin
      commit_done <= copy_c;
      if (copy_c) begin
        for (int i = 0; i < N_POLY; i++) begin
          active[i] <= shadow[i];
        end
        frame_count <= frame_count + CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < N_POLY; g++) begin : g_out
    assign cmp_en[g]                          = active[g].en;
    assign v0_x[g*WPX +: WPX]                 = active[g].v0_x;
    assign v0_y[g*WPY +: WPY]                 = active[g].v0_y;
    assign v1_x[g*WPX +: WPX]                 = active[g].v1_x;
    assign v1_y[g*WPY +: WPY]                 = active[g].v1_y;
    assign v2_x[g*WPX +: WPX]                 = active[g].v2_x;
    assign v2_y[g*WPY +: WPY]                 = active[g].v2_y;
    assign poly_color[g*WCOLOR +: WCOLOR]     = active[g].color;
  end

`ifdef POLY_LOADER_READBACK_EN
  // Zero-extended shadow field; out-of-range polygon indices read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_POLY; i++) begin
      if (rd_poly == PIDX_W'(i)) begin
        case (field_e'(rd_field))
          FLD_V0_X:  rd_data = DATA_W'(shadow[i].v0_x);
          FLD_V0_Y:  rd_data = DATA_W'(shadow[i].v0_y);
          FLD_V1_X:  rd_data = DATA_W'(shadow[i].v1_x);
          FLD_V1_Y:  rd_data = DATA_W'(shadow[i].v1_y);
          FLD_V2_X:  rd_data = DATA_W'(shadow[i].v2_x);
          FLD_V2_Y:  rd_data = DATA_W'(shadow[i].v2_y);
          FLD_COLOR: rd_data = DATA_W'(shadow[i].color);
          FLD_EN:    rd_data = DATA_W'(shadow[i].en);
          default:   rd_data = '0;
        endcase
      end
    end
  end
`endif

endmodule
